// File: rtl/memory_defs.sv
// Shared encodings for the processor memory handshake: data lengths, direction and
// responder FSM states.
package memory_defs;

  localparam logic [1:0] DL_BYTE   = 2'b00;
  localparam logic [1:0] DL_HALF   = 2'b01;
  localparam logic [1:0] DL_WORD   = 2'b10;
  localparam logic [1:0] DL_DOUBLE = 2'b11;

  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StWait2   = 2'd2,
    StRelease = 2'd3
  } mem_state_e;

  // Natural alignment by silently clearing low address bits; no fault is raised.
  function automatic logic [1:0] align_low(input logic [1:0] dl, input logic [1:0] low);
    logic [1:0] res;
    case (dl)
      DL_BYTE: res = low;
      DL_HALF: res = {low[1], 1'b0};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/byte_lane_mem.sv
// Byte-addressed storage with big-endian lane packing for 1/2/4-byte accesses.
// Doubleword length is treated as a word access; the caller sequences the two beats.
module byte_lane_mem
  import memory_defs::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [1:0]        dl_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [7:0]        mem_q [Depth];
  logic [ADDR_W-1:0] addr_p1, addr_p2, addr_p3;

  assign addr_p1 = addr_i + ADDR_W'(1);
  assign addr_p2 = addr_i + ADDR_W'(2);
  assign addr_p3 = addr_i + ADDR_W'(3);

  // Lowest address carries the most significant byte of the access.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      case (dl_i)
        DL_BYTE: mem_q[addr_i] <= wdata_i[7:0];
        DL_HALF: begin
          mem_q[addr_i]  <= wdata_i[15:8];
          mem_q[addr_p1] <= wdata_i[7:0];
        end
        default: begin
          mem_q[addr_i]  <= wdata_i[31:24];
          mem_q[addr_p1] <= wdata_i[23:16];
          mem_q[addr_p2] <= wdata_i[15:8];
          mem_q[addr_p3] <= wdata_i[7:0];
        end
      endcase
    end
  end

  always_comb begin
    rdata_o = '0;
    case (dl_i)
      DL_BYTE: rdata_o = {24'h0, mem_q[addr_i]};
      DL_HALF: rdata_o = {16'h0, mem_q[addr_i], mem_q[addr_p1]};
      default: rdata_o = {mem_q[addr_i], mem_q[addr_p1], mem_q[addr_p2], mem_q[addr_p3]};
    endcase
  end

endmodule

// File: rtl/memory_responder.sv
// Wait-stated, big-endian target for the mov/moc memory handshake; doublewords are
// served as two word beats at address and address+4 (wrapping).
module memory_responder
  import memory_defs::*;
#(
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              mov,
  input  logic              rw,
  input  logic [1:0]        dl,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              moc,
  output logic              busy
);

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  mem_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, rw_d;
  logic [1:0]        dl_q, dl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       data_out_q;
  logic              moc_q;
  logic              beat;
  logic              mem_we;
  logic [31:0]       mem_rdata;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    dl_d    = dl_q;
    addr_d  = addr_q;
    beat    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (mov) begin
          rw_d    = rw;
          dl_d    = dl;
          addr_d  = {address[ADDR_W-1:2], align_low(dl, address[1:0])};
          cnt_d   = WaitInit;
          state_d = StWait;
        end
      end
      StWait, StWait2: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          beat = 1'b1;
          if (state_q == StWait && dl_q == DL_DOUBLE) begin
            state_d = StWait2;
            cnt_d   = WaitInit;
            addr_d  = addr_q + ADDR_W'(4);
          end else begin
            state_d = StRelease;
          end
        end
      end
      StRelease: begin
        if (!mov) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset on the beat edge suppresses the write.
  assign mem_we = beat && (rw_q == RW_WRITE) && !reset;

  byte_lane_mem #(
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk_i  (main_clk),
    .we_i   (mem_we),
    .dl_i   (dl_q),
    .addr_i (addr_q),
    .wdata_i(data_in),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge main_clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      rw_q       <= RW_READ;
      dl_q       <= DL_BYTE;
      addr_q     <= '0;
      data_out_q <= 32'h0;
      moc_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      dl_q    <= dl_d;
      addr_q  <= addr_d;
      moc_q   <= beat;
      if (beat && rw_q == RW_READ) data_out_q <= mem_rdata;
    end
  end

  assign data_out = data_out_q;
  assign moc      = moc_q;
  assign busy     = (state_q != StIdle);

endmodule
